p_reg_file_sb: RTL and testbench
================================

Name: p_reg_file_sb

Overview:
- Parametrised successor to the PSIMD DLFloat register file.
- Provides configurable depth and width, three combinational read ports, and single or paired (rd, rd+1) writeback.
- Adds an optional write-to-read bypass, a per-register pending scoreboard with issue-stall generation, a flush, and a sticky pair-wrap error flag.
- Sits between the PSIMD decode/issue stage and the DLFloat execute writeback.

Parameters:
- REG_WIDTH, 64: bits per register.
- NUM_REGS, 32: register count; power of two, minimum 4.
- ADDR_W, $clog2(NUM_REGS): address width (derived; do not override).
- BYPASS, 1: 1 = a same-cycle writeback is forwarded to the read ports; 0 = reads return stored array contents only.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name).
- rs1_address, rs2_address, rs3_address  in  ADDR_W  read addresses.
- rd_address  in  ADDR_W  writeback destination.
- wr_enable  in  1  writeback strobe.
- reg_fti_ctrl  in  1  1 = single write (dataout_1 to rd); 0 = pair write (dataout_1 to rd, dataout_2 to rd+1).
- dataout_1, dataout_2  in  REG_WIDTH  writeback data.
- data1, data2, data3  out  REG_WIDTH  read data.
- issue_valid  in  1  decode requests issue of an instruction.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- issue_pair  in  1  the issuing instruction writes a pair.
- issue_rs_used  in  3  per-source "operand used" mask, bit0 = rs1.
- issue_stall  out  1  combinational; issue is refused this cycle.
- busy  out  3  combinational; source n is pending and not being forwarded.
- flush  in  1  synchronous clear of all pending bits.
- pending_count  out  ADDR_W+1  registered population count of pending bits.
- wr_err  out  1  sticky; a pair write wrapped past the top register.

Behaviour:
- Reset (rst_n = 1, asynchronous): all registers = 0; all pending bits = 0; pending_count = 0; wr_err = 0. Combinational outputs follow directly (data* = 0, busy = 0).
- Write path:
  - Active when wr_enable = 1 and not in reset.
  - reg_fti_ctrl = 1: REG[rd] <= dataout_1.
  - reg_fti_ctrl = 0: REG[rd] <= dataout_1 and REG[(rd+1) mod NUM_REGS] <= dataout_2.
  - A pair write with rd = NUM_REGS-1 still writes REG[0] and sets wr_err. wr_err clears only on reset.
- Read path:
  - Zero latency, combinational.
  - With BYPASS = 1, a read address matching a location written this cycle returns the incoming data: dataout_1 for rd, dataout_2 for rd+1 in a pair write.
  - With BYPASS = 0, reads return the array value; a new value is visible the cycle after the write.
- Scoreboard, per-register pending bit P[i]:
  - Issue accepted (issue_valid = 1 and issue_stall = 0): sets P[issue_rd]; also sets P[(issue_rd+1) mod NUM_REGS] if issue_pair = 1.
  - Writeback: clears P for every location written.
  - Same register set and cleared in the same cycle: set wins (the new producer owns it).
  - flush = 1: next cycle all P = 0. flush overrides any issue set in that same cycle. Register data is untouched.
- Hazard logic:
  - busy[n] = P[rsn_address] AND NOT (BYPASS = 1 AND rsn_address is being written this cycle).
  - issue_stall = issue_valid AND ( any(busy[n] AND issue_rs_used[n])  (RAW)  OR  P[issue_rd]  OR  (issue_pair AND P[issue_rd+1])  (WAW) ).
  - A stalled issue changes no state.
- pending_count: registered; equals the number of set P bits after each edge; range 0..NUM_REGS.
- Reads and writes to the same address in the same cycle are legal. No port ever blocks the write path.

Decomposition:
- Shared package psimd_rf_pkg holds:
  - default REG_WIDTH and NUM_REGS constants;
  - typedef rf_addr_t;
  - typedef rf_wr_t {en, pair, addr, d1, d2};
  - function pair_addr(addr) returning (addr+1) mod NUM_REGS.
- One natural sub-module: p_rf_scoreboard (pending bits, hazard check, pending_count, flush). The array, write decode and bypass stay in the top level.

Test Plan:
- Reset mid-operation: write 0xAAAA to r5, set P[5], then assert rst_n asynchronously between edges → data1 (rs1 = 5) = 0 immediately; pending_count = 0; busy = 0.
- Pair write: rd = 6, reg_fti_ctrl = 0, d1 = 0x11, d2 = 0x22 → next cycle data1(r6) = 0x11, data2(r7) = 0x22, wr_err = 0. Repeat with rd = 31 → r31 = 0x11, r0 = 0x22, wr_err = 1 and held.
- Bypass: BYPASS = 1, write 0x55 to r3 while rs1 = 3 → data1 = 0x55 in the same cycle. With BYPASS = 0 → old value this cycle, 0x55 next cycle.
- RAW stall: issue rd = 4 (accepted, pending_count = 1), then issue with rs2 = 4 and issue_rs_used = 3'b010 → issue_stall = 1, busy[1] = 1. Writeback to r4 that cycle with BYPASS = 1 → stall drops the same cycle; P[4] = 0 next cycle.
- WAW / pair stall: P[9] set; issue rd = 8 with issue_pair = 1 → issue_stall = 1 and pending_count unchanged. Set and clear of r2 in the same cycle → P[2] = 1.
- Flush: set P for r1, r2, r10 (pending_count = 3), then flush together with a new issue of rd = 12 → pending_count = 0 and P[12] = 0 next cycle; register contents unchanged.

Source files
------------

// File: rtl/psimd_rf_pkg.sv
// Shared types and defaults for the PSIMD register file with scoreboard.
// Contents: default geometry, address and writeback-bundle typedefs, and the
// wrap-around pair-address helper.
package psimd_rf_pkg;

  localparam int unsigned RF_REG_WIDTH = 64;
  localparam int unsigned RF_NUM_REGS  = 32;
  localparam int unsigned RF_ADDR_W    = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // One writeback event: single (pair = 0) or paired (addr, addr+1).
  typedef struct packed {
    logic                    en;
    logic                    pair;
    rf_addr_t                addr;
    logic [RF_REG_WIDTH-1:0] d1;
    logic [RF_REG_WIDTH-1:0] d2;
  } rf_wr_t;

  // Second register of a pair; wraps naturally because NUM_REGS is a power of two.
  function automatic rf_addr_t pair_addr(input rf_addr_t addr);
    return addr + RF_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/p_reg_file_sb_if.sv
// Bus bundle between decode/issue + writeback (master) and the register file (slave).
// Carries: 3 read ports, writeback strobe/data, issue request, hazard outputs,
// flush, pending population count and the sticky pair-wrap error.
interface p_reg_file_sb_if
  import psimd_rf_pkg::*;
#(
  parameter int unsigned REG_WIDTH = RF_REG_WIDTH,
  parameter int unsigned NUM_REGS  = RF_NUM_REGS
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0]    rs1_address;
  logic [ADDR_W-1:0]    rs2_address;
  logic [ADDR_W-1:0]    rs3_address;
  logic [ADDR_W-1:0]    rd_address;
  logic                 wr_enable;
  logic                 reg_fti_ctrl;
  logic [REG_WIDTH-1:0] dataout_1;
  logic [REG_WIDTH-1:0] dataout_2;
  logic [REG_WIDTH-1:0] data1;
  logic [REG_WIDTH-1:0] data2;
  logic [REG_WIDTH-1:0] data3;
  logic                 issue_valid;
  logic [ADDR_W-1:0]    issue_rd;
  logic                 issue_pair;
  logic [2:0]           issue_rs_used;
  logic                 issue_stall;
  logic [2:0]           busy;
  logic                 flush;
  logic [ADDR_W:0]      pending_count;
  logic                 wr_err;

  modport master (
    output rs1_address, rs2_address, rs3_address, rd_address, wr_enable,
           reg_fti_ctrl, dataout_1, dataout_2, issue_valid, issue_rd,
           issue_pair, issue_rs_used, flush,
    input  data1, data2, data3, issue_stall, busy, pending_count, wr_err
  );

  modport slave (
    input  rs1_address, rs2_address, rs3_address, rd_address, wr_enable,
           reg_fti_ctrl, dataout_1, dataout_2, issue_valid, issue_rd,
           issue_pair, issue_rs_used, flush,
    output data1, data2, data3, issue_stall, busy, pending_count, wr_err
  );

endinterface

// File: rtl/p_rf_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, flush wipes.
// Ports: clk, rst_n (active-high async reset), flush, issue request
// (valid/rd/pair/rs_used), the three read addresses, the writeback location
// mask; outputs busy[2:0], issue_stall (combinational), pending_count (registered).
module p_rf_scoreboard
  import psimd_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0]  issue_rd,
  input  logic                         issue_pair,
  input  logic [2:0]                   issue_rs_used,
  input  logic [$clog2(NUM_REGS)-1:0]  rs1_address,
  input  logic [$clog2(NUM_REGS)-1:0]  rs2_address,
  input  logic [$clog2(NUM_REGS)-1:0]  rs3_address,
  input  logic [NUM_REGS-1:0]          wr_mask,
  output logic [2:0]                   busy,
  output logic                         issue_stall,
  output logic [$clog2(NUM_REGS):0]    pending_count
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic        BYP    = (BYPASS != 0);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_next;
  logic [NUM_REGS-1:0] set_mask;
  logic [CNT_W-1:0]    cnt_next;
  logic [ADDR_W-1:0]   issue_rd_p1;
  logic                raw_hit;
  logic                waw_hit;
  logic                accept;

  assign issue_rd_p1 = issue_rd + ADDR_W'(1);

  // A source is busy only if its producer is not being forwarded this cycle.
  always_comb begin
    busy[0] = pend[rs1_address] & ~(BYP & wr_mask[rs1_address]);
    busy[1] = pend[rs2_address] & ~(BYP & wr_mask[rs2_address]);
    busy[2] = pend[rs3_address] & ~(BYP & wr_mask[rs3_address]);
  end

  // WAW looks at the stored bits: an in-flight write to rd still owns it until the edge.
  assign raw_hit     = |(busy & issue_rs_used);
  assign waw_hit     = pend[issue_rd] | (issue_pair & pend[issue_rd_p1]);
  assign issue_stall = issue_valid & (raw_hit | waw_hit);
  assign accept      = issue_valid & ~issue_stall;

  // Next pending vector: set beats clear, flush beats everything.
  always_comb begin
    set_mask = '0;
    if (accept) begin
      set_mask[issue_rd] = 1'b1;
      if (issue_pair) set_mask[issue_rd_p1] = 1'b1;
    end
    pend_next = flush ? '0 : ((pend & ~wr_mask) | set_mask);
    cnt_next  = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt_next = cnt_next + CNT_W'(pend_next[i]);
    end
  end

  // Pending bits and their registered population count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend          <= '0;
      pending_count <= '0;
    end else begin
      pend          <= pend_next;
      pending_count <= cnt_next;
    end
  end

endmodule

// File: rtl/p_reg_file_sb.sv
// PSIMD DLFloat register file with three combinational read ports, single or
// paired writeback, optional write-to-read bypass and a pending scoreboard.
// Ports: clk, rst_n (active-high async reset despite the name), bus (slave
// modport carrying read/write/issue/flush signals and hazard/status outputs).
module p_reg_file_sb
  import psimd_rf_pkg::*;
#(
  parameter int unsigned REG_WIDTH = RF_REG_WIDTH,
  parameter int unsigned NUM_REGS  = RF_NUM_REGS,
  parameter int unsigned BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  p_reg_file_sb_if.slave    bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam logic        BYP    = (BYPASS != 0);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  wr_mask;
  logic [ADDR_W-1:0]    rd_p1;
  logic                 pair_wr;
  logic [ADDR_W-1:0]    rs_addr [3];
  logic [REG_WIDTH-1:0] rs_data [3];

  assign rd_p1   = bus.rd_address + ADDR_W'(1);
  assign pair_wr = bus.wr_enable & ~bus.reg_fti_ctrl;

  // Locations touched by this cycle's writeback.
  always_comb begin
    wr_mask = '0;
    if (bus.wr_enable) begin
      wr_mask[bus.rd_address] = 1'b1;
      if (!bus.reg_fti_ctrl) wr_mask[rd_p1] = 1'b1;
    end
  end

  // Register array and sticky wrap error; a wrapping pair still writes REG[0].
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      bus.wr_err <= 1'b0;
    end else if (bus.wr_enable) begin
      regs[bus.rd_address] <= bus.dataout_1;
      if (!bus.reg_fti_ctrl) begin
        regs[rd_p1] <= bus.dataout_2;
        if (bus.rd_address == ADDR_W'(NUM_REGS - 1)) bus.wr_err <= 1'b1;
      end
    end
  end

  // Read muxes with optional same-cycle forwarding of the writeback data.
  always_comb begin
    rs_addr[0] = bus.rs1_address;
    rs_addr[1] = bus.rs2_address;
    rs_addr[2] = bus.rs3_address;
    for (int n = 0; n < 3; n++) begin
      rs_data[n] = regs[rs_addr[n]];
      if (BYP && bus.wr_enable && rs_addr[n] == bus.rd_address) begin
        rs_data[n] = bus.dataout_1;
      end else if (BYP && pair_wr && rs_addr[n] == rd_p1) begin
        rs_data[n] = bus.dataout_2;
      end
    end
  end

  assign bus.data1 = rs_data[0];
  assign bus.data2 = rs_data[1];
  assign bus.data3 = rs_data[2];

  p_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (bus.flush),
    .issue_valid   (bus.issue_valid),
    .issue_rd      (bus.issue_rd),
    .issue_pair    (bus.issue_pair),
    .issue_rs_used (bus.issue_rs_used),
    .rs1_address   (bus.rs1_address),
    .rs2_address   (bus.rs2_address),
    .rs3_address   (bus.rs3_address),
    .wr_mask       (wr_mask),
    .busy          (bus.busy),
    .issue_stall   (bus.issue_stall),
    .pending_count (bus.pending_count)
  );

endmodule

// File: tb/tb_p_reg_file_sb.sv
// Directed bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_p_reg_file_sb;

  localparam int unsigned W = 64;
  localparam int unsigned N = 32;
  localparam int unsigned A = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [A-1:0] rs1_address, rs2_address, rs3_address, rd_address, issue_rd;
  logic         wr_enable, reg_fti_ctrl, issue_valid, issue_pair, flush;
  logic [W-1:0] dataout_1, dataout_2;
  logic [2:0]   issue_rs_used;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  p_reg_file_sb_if #(.REG_WIDTH(W), .NUM_REGS(N)) b1 ();
  p_reg_file_sb_if #(.REG_WIDTH(W), .NUM_REGS(N)) b0 ();

  assign b1.rs1_address   = rs1_address;   assign b0.rs1_address   = rs1_address;
  assign b1.rs2_address   = rs2_address;   assign b0.rs2_address   = rs2_address;
  assign b1.rs3_address   = rs3_address;   assign b0.rs3_address   = rs3_address;
  assign b1.rd_address    = rd_address;    assign b0.rd_address    = rd_address;
  assign b1.wr_enable     = wr_enable;     assign b0.wr_enable     = wr_enable;
  assign b1.reg_fti_ctrl  = reg_fti_ctrl;  assign b0.reg_fti_ctrl  = reg_fti_ctrl;
  assign b1.dataout_1     = dataout_1;     assign b0.dataout_1     = dataout_1;
  assign b1.dataout_2     = dataout_2;     assign b0.dataout_2     = dataout_2;
  assign b1.issue_valid   = issue_valid;   assign b0.issue_valid   = issue_valid;
  assign b1.issue_rd      = issue_rd;      assign b0.issue_rd      = issue_rd;
  assign b1.issue_pair    = issue_pair;    assign b0.issue_pair    = issue_pair;
  assign b1.issue_rs_used = issue_rs_used; assign b0.issue_rs_used = issue_rs_used;
  assign b1.flush         = flush;         assign b0.flush         = flush;

  p_reg_file_sb #(.REG_WIDTH(W), .NUM_REGS(N), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  p_reg_file_sb #(.REG_WIDTH(W), .NUM_REGS(N), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .bus(b0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_enable = 1'b0; reg_fti_ctrl = 1'b1; issue_valid = 1'b0; issue_pair = 1'b0;
    issue_rs_used = 3'b000; flush = 1'b0;
  endtask

  task automatic issue(input logic [A-1:0] rd);
    issue_valid = 1'b1; issue_rd = rd; issue_pair = 1'b0; issue_rs_used = 3'b000;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    rs1_address = '0; rs2_address = '0; rs3_address = '0; rd_address = '0;
    issue_rd = '0; dataout_1 = '0; dataout_2 = '0;
    idle();
    rst_n = 1'b1;
    #3;
    chk("rst_data1", b1.data1, 64'h0);
    chk("rst_pcnt", 64'(b1.pending_count), 64'h0);
    chk("rst_werr", 64'(b1.wr_err), 64'h0);
    #19 rst_n = 1'b0;
    tick();

    // reset mid-operation
    wr_enable = 1'b1; rd_address = 5; dataout_1 = 64'hAAAA;
    issue_valid = 1'b1; issue_rd = 5;
    tick();
    idle(); rs1_address = 5;
    #1;
    chk("pre_rst_data1", b0.data1, 64'hAAAA);
    chk("pre_rst_pcnt", 64'(b1.pending_count), 64'd1);
    chk("pre_rst_busy", 64'(b1.busy), 64'b001);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_data1", b0.data1, 64'h0);
    chk("mid_rst_pcnt", 64'(b1.pending_count), 64'd0);
    chk("mid_rst_busy", 64'(b1.busy), 64'b000);
    rst_n = 1'b0;
    tick();

    // pair write, then wrapping pair write
    wr_enable = 1'b1; reg_fti_ctrl = 1'b0; rd_address = 6;
    dataout_1 = 64'h11; dataout_2 = 64'h22;
    tick();
    idle(); rs1_address = 6; rs2_address = 7;
    #1;
    chk("pair_d1", b0.data1, 64'h11);
    chk("pair_d2", b0.data2, 64'h22);
    chk("pair_werr", 64'(b0.wr_err), 64'h0);
    wr_enable = 1'b1; reg_fti_ctrl = 1'b0; rd_address = 31;
    tick();
    idle(); rs1_address = 31; rs2_address = 0;
    #1;
    chk("wrap_d1", b0.data1, 64'h11);
    chk("wrap_d2", b0.data2, 64'h22);
    chk("wrap_werr", 64'(b0.wr_err), 64'h1);
    tick();
    chk("wrap_werr_held", 64'(b1.wr_err), 64'h1);

    // bypass vs stored read
    wr_enable = 1'b1; rd_address = 3; dataout_1 = 64'h55; rs1_address = 3;
    #1;
    chk("byp_same_cycle", b1.data1, 64'h55);
    chk("nob_same_cycle", b0.data1, 64'h0);
    tick();
    idle();
    #1;
    chk("nob_next_cycle", b0.data1, 64'h55);

    // RAW stall and its release by a bypassed writeback
    issue_valid = 1'b1; issue_rd = 4;
    #1;
    chk("raw_first_nostall", 64'(b1.issue_stall), 64'h0);
    tick();
    idle();
    chk("raw_pcnt1", 64'(b1.pending_count), 64'd1);
    issue_valid = 1'b1; issue_rd = 13; rs1_address = 0; rs2_address = 4; rs3_address = 0;
    issue_rs_used = 3'b010;
    #1;
    chk("raw_stall", 64'(b1.issue_stall), 64'h1);
    chk("raw_busy", 64'(b1.busy), 64'b010);
    wr_enable = 1'b1; rd_address = 4; dataout_1 = 64'h44;
    #1;
    chk("raw_byp_release", 64'(b1.issue_stall), 64'h0);
    chk("raw_byp_busy", 64'(b1.busy), 64'b000);
    chk("raw_nob_stall", 64'(b0.issue_stall), 64'h1);
    tick();
    idle();
    chk("raw_byp_pcnt", 64'(b1.pending_count), 64'd1);
    chk("raw_nob_pcnt", 64'(b0.pending_count), 64'd0);
    #1;
    chk("raw_p4_clear", 64'(b1.busy), 64'b000);
    flush = 1'b1;
    tick();
    idle();
    chk("flush_pcnt", 64'(b1.pending_count), 64'd0);

    // WAW on pair, set-and-clear same register
    issue(9);
    chk("waw_pcnt1", 64'(b1.pending_count), 64'd1);
    issue_valid = 1'b1; issue_rd = 8; issue_pair = 1'b1;
    #1;
    chk("waw_pair_stall", 64'(b1.issue_stall), 64'h1);
    tick();
    idle();
    chk("waw_pcnt_same", 64'(b1.pending_count), 64'd1);
    issue_valid = 1'b1; issue_rd = 2; wr_enable = 1'b1; reg_fti_ctrl = 1'b1;
    rd_address = 2; dataout_1 = 64'h2;
    tick();
    idle();
    chk("setclr_pcnt", 64'(b1.pending_count), 64'd2);
    issue_valid = 1'b1; issue_rd = 2;
    #1;
    chk("setclr_p2_set", 64'(b1.issue_stall), 64'h1);
    idle();
    flush = 1'b1;
    tick();
    idle();

    // flush overrides a same-cycle issue
    issue(1); issue(2); issue(10);
    chk("fl_pcnt3", 64'(b1.pending_count), 64'd3);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 12;
    tick();
    idle();
    chk("fl_pcnt0", 64'(b1.pending_count), 64'd0);
    issue_valid = 1'b1; issue_rd = 12;
    rs1_address = 3; rs2_address = 4; rs3_address = 6;
    #1;
    chk("fl_p12_clear", 64'(b1.issue_stall), 64'h0);
    chk("fl_data1", b1.data1, 64'h55);
    chk("fl_data2", b0.data2, 64'h44);
    chk("fl_data3", b1.data3, 64'h11);
    chk("fl_werr", 64'(b0.wr_err), 64'h1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
